// File: rtl/alu_mdu.sv
// Single-cycle ALU with an iterative multiply/divide unit and HI/LO registers.
// Mul/div results are presented combinationally during DONE and committed on its exit edge.
module alu_mdu #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   sa,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OpAnd  = 5'd0,  OpOr   = 5'd1,  OpXor  = 5'd2,  OpNor  = 5'd3;
  localparam logic [4:0] OpLui  = 5'd4,  OpSll  = 5'd5,  OpSrl  = 5'd6,  OpSra  = 5'd7;
  localparam logic [4:0] OpSllv = 5'd8,  OpSrlv = 5'd9,  OpSrav = 5'd10, OpAdd  = 5'd11;
  localparam logic [4:0] OpAddu = 5'd12, OpSub  = 5'd13, OpSubu = 5'd14, OpSlt  = 5'd15;
  localparam logic [4:0] OpSltu = 5'd16, OpMult = 5'd17, OpMultu = 5'd18, OpDiv = 5'd19;
  localparam logic [4:0] OpDivu = 5'd20, OpMfhi = 5'd21, OpMflo = 5'd22, OpMthi = 5'd23;
  localparam logic [4:0] OpMtlo = 5'd24;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             st_q, st_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] add_res, sub_res, alu_y;
  logic             alu_ovf;
  logic [SHW-1:0]   vsa;

  assign add_res = a + b;
  assign sub_res = a - b;
  assign vsa     = a[SHW-1:0];

  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (op)
      OpAnd:  alu_y = a & b;
      OpOr:   alu_y = a | b;
      OpXor:  alu_y = a ^ b;
      OpNor:  alu_y = ~(a | b);
      OpLui:  alu_y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OpSll:  alu_y = b << sa;
      OpSrl:  alu_y = b >> sa;
      OpSra:  alu_y = $signed(b) >>> sa;
      OpSllv: alu_y = b << vsa;
      OpSrlv: alu_y = b >> vsa;
      OpSrav: alu_y = $signed(b) >>> vsa;
      OpAdd: begin
        alu_y   = add_res;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpAddu: alu_y = add_res;
      OpSub: begin
        alu_y   = sub_res;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSubu: alu_y = sub_res;
      OpSlt:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OpMfhi: alu_y = hi_q;
      OpMflo: alu_y = lo_q;
      OpMthi: alu_y = a;
      OpMtlo: alu_y = a;
      default: alu_y = '0;
    endcase
  end

  // Mul/div operate on magnitudes; signs are reapplied in DONE
  logic             is_mul, is_div, is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign is_mul    = (op == OpMult) || (op == OpMultu);
  assign is_div    = (op == OpDiv) || (op == OpDivu);
  assign is_signed = (op == OpMult) || (op == OpDiv);
  assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & dvs_q};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  // acc = {remainder, dividend/quotient}; quotient bits shift in from the bottom
  assign div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = {1'b0, div_sh} - {2'b00, dvs_q};
  assign div_ok    = ~div_trial[WIDTH+1];
  assign div_next  = {div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ok};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
  logic               done_fire;

  assign prod_fix = qneg_q ? -acc_q : acc_q;
  assign quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (dvs_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  assign done_fire = (st_q == StDone) && resetn && !flush;
  assign in_ready  = (st_q == StIdle) && resetn;

  assign out_valid = out_valid_q | done_fire;
  assign y         = done_fire ? res_lo : y_q;
  assign ovf       = ovf_q & ~done_fire;
  assign hi        = done_fire ? res_hi : hi_q;
  assign lo        = done_fire ? res_lo : lo_q;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    a_d         = a_q;
    div_d       = div_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    out_valid_d = 1'b0;
    y_d         = y_q;
    ovf_d       = ovf_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    unique case (st_q)
      StIdle: begin
        if (in_valid && in_ready && !flush) begin
          if (is_mul || is_div) begin
            st_d   = is_mul ? StMul : StDiv;
            cnt_d  = '0;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            dvs_d  = abs_b;
            a_d    = a;
            div_d  = is_div;
            qneg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = is_signed && a[WIDTH-1];
          end else begin
            out_valid_d = 1'b1;
            y_d         = alu_y;
            ovf_d       = alu_ovf;
            if (op == OpMthi) hi_d = a;
            if (op == OpMtlo) lo_d = a;
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (st_q == StMul) ? mul_next : div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          cnt_d = '0;
          st_d  = StDone;
        end
      end
      StDone: begin
        st_d = StIdle;
        if (done_fire) begin
          hi_d  = res_hi;
          lo_d  = res_lo;
          y_d   = res_lo;
          ovf_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase

    if (flush && (st_q != StIdle)) begin
      st_d  = StIdle;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      a_q         <= '0;
      div_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      a_q         <= a_d;
      div_q       <= div_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: expected results are queued at issue and checked at out_valid.
module tb_alu_mdu;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic [W-1:0]  a, b;
  logic [4:0]    sa;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  y;
  logic          ovf;
  logic [W-1:0]  hi, lo;

  logic          in_valid16, in_ready16, out_valid16, ovf16;
  logic [4:0]    op16;
  logic [15:0]   a16, b16, y16, hi16, lo16;
  logic [3:0]    sa16;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .sa(sa), .flush(flush), .out_valid(out_valid), .y(y), .ovf(ovf),
    .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .sa(sa16), .flush(flush), .out_valid(out_valid16), .y(y16),
    .ovf(ovf16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] y;
    logic         ovf;
    logic         chk_hl;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      check("out_valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".y"}, 64'(y), 64'(e.y));
        check({e.tag, ".ovf"}, 64'(ovf), 64'(e.ovf));
        check({e.tag, ".latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
        if (e.chk_hl) begin
          check({e.tag, ".hi"}, 64'(hi), 64'(e.hi));
          check({e.tag, ".lo"}, 64'(lo), 64'(e.lo));
        end
      end
    end
  end

  task automatic issue(input string tag, input logic [4:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [4:0] isa, input logic [W-1:0] ey,
                       input logic eo, input logic chk, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input int lat);
    exp_t e;
    @(negedge clk);
    op = o; a = ia; b = ib; sa = isa; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.tag = tag; e.y = ey; e.ovf = eo; e.chk_hl = chk; e.hi = ehi; e.lo = elo;
    e.lat = lat; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic single(input string tag, input logic [4:0] o, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [4:0] isa, input logic [W-1:0] ey,
                        input logic eo);
    issue(tag, o, ia, ib, isa, ey, eo, 1'b0, '0, '0, 1);
  endtask

  task automatic mdu(input string tag, input logic [4:0] o, input logic [W-1:0] ia,
                     input logic [W-1:0] ib, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    issue(tag, o, ia, ib, 5'd0, elo, 1'b0, 1'b1, ehi, elo, W + 1);
  endtask

  task automatic start(input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic rdy_bad;
    int   acc16;
    int   lat16;
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; sa = '0;
    in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sa16 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 0);
    check("rst.y", 64'(y), 0);
    check("rst.ovf", 64'(ovf), 0);
    check("rst.hi", 64'(hi), 0);
    check("rst.lo", 64'(lo), 0);
    check("rst.in_ready", 64'(in_ready), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst.in_ready_after", 64'(in_ready), 1);

    // Single-cycle ops, issued back to back
    single("add",  5'd11, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1);
    single("addu", 5'd12, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0);
    single("sub",  5'd13, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1);
    single("subu", 5'd14, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0);
    single("and",  5'd0, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'h00F01200, 1'b0);
    single("or",   5'd1, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'hFFF0FF34, 1'b0);
    single("xor",  5'd2, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'hFF00ED34, 1'b0);
    single("nor",  5'd3, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'h000F00CB, 1'b0);
    single("lui",  5'd4, 32'h0, 32'hABCD1234, 5'd0, 32'h12340000, 1'b0);
    single("sll",  5'd5, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0);
    single("srl",  5'd6, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0);
    single("sra",  5'd7, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0);
    single("sra0", 5'd7, 32'h0, 32'h80000001, 5'd0, 32'h80000001, 1'b0);
    single("sllv", 5'd8, 32'h24, 32'hF, 5'd0, 32'hF0, 1'b0);
    single("srlv", 5'd9, 32'h21, 32'h80000000, 5'd0, 32'h40000000, 1'b0);
    single("srav", 5'd10, 32'h0, 32'h80000000, 5'd0, 32'h80000000, 1'b0);
    single("slt",  5'd15, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0);
    single("sltu", 5'd16, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    single("op25", 5'd25, 32'h5, 32'h5, 5'd3, 32'h0, 1'b0);
    single("mtlo", 5'd24, 32'h1234, 32'h0, 5'd0, 32'h1234, 1'b0);
    single("mflo", 5'd22, 32'h0, 32'h0, 5'd0, 32'h1234, 1'b0);
    single("mthi", 5'd23, 32'hCAFE, 32'h0, 5'd0, 32'hCAFE, 1'b0);
    single("mfhi", 5'd21, 32'h0, 32'h0, 5'd0, 32'hCAFE, 1'b0);
    drain(4);

    // MULT with operands scrambled while busy; in_ready must stay low
    mdu("mult", 5'd17, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    rdy_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 5'($urandom);
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      #1;
      if (sb.size() == 0) break;
    end
    check("mult.in_ready_low", 64'(rdy_bad), 0);
    drain(2);
    single("mfhi_after_mult", 5'd21, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
    drain(4);

    mdu("multu",   5'd18, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);        drain(40);
    mdu("div",     5'd19, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD); drain(40);
    mdu("div_pos", 5'd19, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);        drain(40);
    mdu("divu_z",  5'd20, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF);               drain(40);
    mdu("div_z",   5'd19, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF); drain(40);
    mdu("div_min", 5'd19, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000); drain(40);
    mdu("divu",    5'd20, 32'd100, 32'd7, 32'd2, 32'd14);                   drain(40);
    single("mflo_after_divu", 5'd22, 32'h0, 32'h0, 5'd0, 32'd14, 1'b0);
    drain(4);

    // Flush in cycle 10 of a DIVU: no result, HI/LO keep 2/14
    start(5'd20, 32'd9, 32'd2);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush.in_ready", 64'(in_ready), 1);
    check("flush.hi", 64'(hi), 64'd2);
    check("flush.lo", 64'(lo), 64'd14);
    check("flush.out_valid", 64'(out_valid), 0);
    repeat (W + 5) @(negedge clk);
    check("flush.lo_later", 64'(lo), 64'd14);

    // Reset in the middle of a DIVU
    start(5'd20, 32'd9, 32'd2);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid.out_valid", 64'(out_valid), 0);
    check("rst_mid.y", 64'(y), 0);
    check("rst_mid.ovf", 64'(ovf), 0);
    check("rst_mid.hi", 64'(hi), 0);
    check("rst_mid.lo", 64'(lo), 0);
    check("rst_mid.in_ready", 64'(in_ready), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_mid.in_ready_after", 64'(in_ready), 1);
    repeat (W + 5) @(negedge clk);
    check("rst_mid.lo_later", 64'(lo), 0);

    // WIDTH=16 MULT -3*7: latency 17
    @(negedge clk);
    op16 = 5'd17; a16 = 16'hFFFD; b16 = 16'h7; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    acc16 = cyc;
    lat16 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid16 === 1'b1) begin
        lat16 = cyc - acc16 + 1;
        check("w16.hi", 64'(hi16), 64'hFFFF);
        check("w16.lo", 64'(lo16), 64'hFFEB);
        break;
      end
    end
    check("w16.latency", 64'(lat16), 64'd17);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
